// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake bundle and sync_fifo write port shared by the arbiter.
// master = producers/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 16
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ-1:0]        req_ready;
   logic                    fifo_full;
   logic                    fifo_wr_en;
   logic [DATA_W-1:0]       fifo_din;

   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_din
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_din
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the sync_fifo write port between N_REQ producers.
// A grant costs one IDLE cycle and lasts up to MAX_BURST accepted words.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   fifo_wr_arbiter_if.slave         bus,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy
);
   localparam int OWN_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state_reg, state_next;
   logic [OWN_W-1:0]   owner_reg, owner_next;
   logic [OWN_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

   logic [DATA_W-1:0]  data_arr [N_REQ];
   logic               sel_valid;
   logic [OWN_W-1:0]   sel_idx;
   logic [OWN_W-1:0]   scan_idx;
   logic               xfer;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
   end

   // Cyclic priority search starting at rr_ptr; first valid index wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      scan_idx  = rr_ptr_reg;
      for (int k = 0; k < N_REQ; k++) begin
         if (!sel_valid && bus.req_valid[scan_idx]) begin
            sel_valid = 1'b1;
            sel_idx   = scan_idx;
         end
         scan_idx = (scan_idx == OWN_W'(N_REQ - 1)) ? '0 : scan_idx + OWN_W'(1);
      end
   end

   always_comb begin
      state_next     = state_reg;
      owner_next     = owner_reg;
      rr_ptr_next    = rr_ptr_reg;
      beat_cnt_next  = beat_cnt_reg;
      bus.req_ready  = '0;
      bus.fifo_wr_en = 1'b0;
      bus.fifo_din   = '0;
      busy           = 1'b0;
      xfer           = 1'b0;

      case (state_reg)
         IDLE: begin
            if (sel_valid) begin
               owner_next    = sel_idx;
               beat_cnt_next = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            busy                     = 1'b1;
            bus.req_ready[owner_reg] = !bus.fifo_full;
            xfer                     = bus.req_valid[owner_reg] && !bus.fifo_full;
            bus.fifo_wr_en           = xfer;
            if (xfer) begin
               bus.fifo_din  = data_arr[owner_reg];
               beat_cnt_next = beat_cnt_reg + CNT_W'(1);
            end
            // A full-FIFO stall with valid held is not a release.
            if ((xfer && (bus.req_last[owner_reg] ||
                          beat_cnt_reg == CNT_W'(MAX_BURST - 1))) ||
                !bus.req_valid[owner_reg]) begin
               state_next  = IDLE;
               rr_ptr_next = (owner_reg == OWN_W'(N_REQ - 1)) ? '0 : owner_reg + OWN_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         rr_ptr_reg   <= '0;
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   assign owner = owner_reg;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester source queues, expected-write
// scoreboard drained by a negedge monitor, plus cycle-exact directed checks.
module tb_fifo_wr_arbiter;
   localparam int N_REQ     = 4;
   localparam int DATA_W    = 16;
   localparam int MAX_BURST = 4;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              l;
   } word_t;

   typedef struct packed {
      logic [1:0]        own;
      logic [DATA_W-1:0] d;
   } exp_t;

   logic       clk  = 1'b0;
   logic       rstn = 1'b1;
   logic [1:0] owner;
   logic       busy;

   word_t src_q [N_REQ][$];
   exp_t  exp_q [$];
   int    n_tests  = 0;
   int    n_fail   = 0;
   int    wr_count = 0;
   int    wr_start = 0;

   fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus),
      .owner (owner),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N_REQ; i++) begin
         if (src_q[i].size() > 0) begin
            bus.req_valid[i]                   = 1'b1;
            bus.req_data[i*DATA_W +: DATA_W]   = src_q[i][0].d;
            bus.req_last[i]                    = src_q[i][0].l;
         end else begin
            bus.req_valid[i]                   = 1'b0;
            bus.req_data[i*DATA_W +: DATA_W]   = '0;
            bus.req_last[i]                    = 1'b0;
         end
      end
   endtask

   task automatic add(input int r, input logic [DATA_W-1:0] d, input logic l);
      word_t w;
      w.d = d;
      w.l = l;
      src_q[r].push_back(w);
   endtask

   task automatic expect_wr(input int r, input logic [DATA_W-1:0] d);
      exp_t e;
      e.own = 2'(r);
      e.d   = d;
      exp_q.push_back(e);
   endtask

   function automatic bit srcs_empty();
      for (int i = 0; i < N_REQ; i++)
         if (src_q[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Inputs change only at posedge+1 (source pops) or posedge+2 (stimulus).
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      tick();
      rstn = 1'b0;
      for (int i = 0; i < N_REQ; i++) src_q[i].delete();
      bus.fifo_full = 1'b0;
      drive();
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         if (!busy && srcs_empty()) done = 1'b1;
      end
      chk({name, "_reached_idle"}, 32'(done), 32'd1);
   endtask

   // Source model: a word leaves its queue once accepted at a rising edge.
   initial begin
      logic [N_REQ-1:0] acc;
      forever begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         drive();
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.fifo_wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: din=%0h owner=%0d, required no write",
                        bus.fifo_din, owner);
            end else begin
               e = exp_q.pop_front();
               chk("wr_din", 32'(bus.fifo_din), 32'(e.d));
               chk("wr_owner", 32'(owner), 32'(e.own));
               chk("wr_ready_onehot", 32'(bus.req_ready), 32'(1) << e.own);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.fifo_full = 1'b0;
      #1 rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_din", 32'(bus.fifo_din), 32'd0);
      chk("rst_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
      chk("rst_beat_cnt", 32'(dut.beat_cnt_reg), 32'd0);
      tick();
      rstn = 1'b1;

      // Single requester, three words ending with last.
      tick();
      add(1, 16'h00A1, 1'b0); add(1, 16'h00A2, 1'b0); add(1, 16'h00A3, 1'b1);
      expect_wr(1, 16'h00A1); expect_wr(1, 16'h00A2); expect_wr(1, 16'h00A3);
      drive();
      @(negedge clk);
      chk("A_idle_busy", 32'(busy), 32'd0);
      chk("A_idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("A_burst_busy", 32'(busy), 32'd1);
         chk("A_burst_wr_en", 32'(bus.fifo_wr_en), 32'd1);
      end
      @(negedge clk);
      #1;
      chk("A_release_busy", 32'(busy), 32'd0);
      chk("A_rr_ptr", 32'(dut.rr_ptr_reg), 32'd2);
      chk("A_owner_hold", 32'(owner), 32'd1);
      chk("A_sb_empty", 32'(exp_q.size()), 32'd0);

      // All four continuously valid: order 0,1,2,3,0, 20 words in 25 cycles.
      do_reset();
      tick();
      for (int r = 0; r < N_REQ; r++)
         for (int n = 0; n < 8; n++) add(r, DATA_W'(r*256 + n), 1'b0);
      for (int b = 0; b < 5; b++)
         for (int n = 0; n < MAX_BURST; n++)
            expect_wr(b % 4, DATA_W'((b % 4)*256 + (b / 4)*4 + n));
      drive();
      wr_start = wr_count;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk($sformatf("B_wr_en_c%0d", c), 32'(bus.fifo_wr_en), 32'((c % 5) != 0));
      end
      #1;
      chk("B_words_in_25", 32'(wr_count - wr_start), 32'd20);
      chk("B_sb_empty", 32'(exp_q.size()), 32'd0);

      // Req 0 stalled by fifo_full for 2 cycles after beat 2.
      do_reset();
      tick();
      for (int n = 0; n < 4; n++) begin
         add(0, DATA_W'(16'hC0 + n), 1'b0);
         expect_wr(0, DATA_W'(16'hC0 + n));
      end
      drive();
      @(negedge clk);
      chk("C_idle_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("C_pre_wr_en", 32'(bus.fifo_wr_en), 32'd1);
      end
      tick();
      bus.fifo_full = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("C_stall_wr_en", 32'(bus.fifo_wr_en), 32'd0);
         chk("C_stall_ready", 32'(bus.req_ready), 32'd0);
         chk("C_stall_beat", 32'(dut.beat_cnt_reg), 32'd2);
         chk("C_stall_busy", 32'(busy), 32'd1);
      end
      tick();
      bus.fifo_full = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("C_post_wr_en", 32'(bus.fifo_wr_en), 32'd1);
      end
      @(negedge clk);
      #1;
      chk("C_release_busy", 32'(busy), 32'd0);
      chk("C_rr_ptr", 32'(dut.rr_ptr_reg), 32'd1);
      chk("C_sb_empty", 32'(exp_q.size()), 32'd0);

      // Req 1 drops valid after 2 beats; req 3 waiting, req 2 idle.
      tick();
      add(1, 16'h00D0, 1'b0); add(1, 16'h00D1, 1'b0);
      add(3, 16'h00D8, 1'b0); add(3, 16'h00D9, 1'b1);
      expect_wr(1, 16'h00D0); expect_wr(1, 16'h00D1);
      expect_wr(3, 16'h00D8); expect_wr(3, 16'h00D9);
      drive();
      @(negedge clk);
      chk("D_idle_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("D_drop_busy", 32'(busy), 32'd1);
      chk("D_drop_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      @(negedge clk);
      chk("D_gap_busy", 32'(busy), 32'd0);
      chk("D_rr_ptr", 32'(dut.rr_ptr_reg), 32'd2);
      @(negedge clk);
      chk("D_grant3_owner", 32'(owner), 32'd3);
      chk("D_grant3_wr_en", 32'(bus.fifo_wr_en), 32'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("D_release_busy", 32'(busy), 32'd0);
      chk("D_rr_wrap", 32'(dut.rr_ptr_reg), 32'd0);

      // Reset mid-burst (owner 2, beat 1), then req 2 regrant and req 3 last on beat 4.
      tick();
      for (int n = 0; n < 4; n++) begin
         add(2, DATA_W'(16'hE0 + n), 1'(n == 3));
         add(3, DATA_W'(16'hF0 + n), 1'(n == 3));
      end
      for (int n = 0; n < 4; n++) expect_wr(2, DATA_W'(16'hE0 + n));
      for (int n = 0; n < 4; n++) expect_wr(3, DATA_W'(16'hF0 + n));
      drive();
      wr_start = wr_count;
      @(negedge clk);
      @(negedge clk);
      chk("E_pre_owner", 32'(owner), 32'd2);
      tick();
      chk("E_pre_beat", 32'(dut.beat_cnt_reg), 32'd1);
      rstn = 1'b0;
      #1;
      chk("E_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
      chk("E_rst_busy", 32'(busy), 32'd0);
      chk("E_rst_ready", 32'(bus.req_ready), 32'd0);
      chk("E_rst_owner", 32'(owner), 32'd0);
      chk("E_rst_din", 32'(bus.fifo_din), 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      @(negedge clk);
      chk("E_post_owner", 32'(owner), 32'd0);
      chk("E_post_rr_ptr", 32'(dut.rr_ptr_reg), 32'd0);
      chk("E_post_busy", 32'(busy), 32'd0);
      wait_idle("E", 40);
      repeat (3) @(negedge clk);
      #1;
      chk("F_rr_wrap", 32'(dut.rr_ptr_reg), 32'd0);
      chk("F_busy", 32'(busy), 32'd0);
      chk("EF_words", 32'(wr_count - wr_start), 32'd8);
      chk("EF_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
